// File: rtl/tile_sprite_renderer.sv
// tile_sprite_renderer: VGA pixel-colour stage.
// Tile-map lookup, 16-entry palette and outlined player sprite.
module tile_sprite_renderer #(
    parameter int unsigned TILE_COLS   = 40,
    parameter int unsigned PLAYER_SIZE = 12,
    parameter logic [23:0] PLAYER_FILL = 24'hFF0000,
    parameter logic [23:0] PLAYER_EDGE = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [10:0] map_addr,
    input  logic [3:0]  map_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [23:0] pal_data,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out,
    output logic        frame_start
);
    localparam logic [10:0] COLS = 11'(TILE_COLS);
    localparam logic [10:0] SPAN = 11'(PLAYER_SIZE - 1);

    logic [9:0]  x1_q, x1_d, y1_q, y1_d;
    logic        b1_q, b1_d, h1_q, h1_d, v1_q, v1_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [9:0]  px_s_q, px_s_d, py_s_q, py_s_d;
    logic [23:0] pal_q [16];
    logic [23:0] pal_d [16];
    logic        latch;
    logic [10:0] x_e, y_e, px_lo, px_hi, py_lo, py_hi;
    logic        hit, on_edge;

    // Stage 0: tile-map address and frame-start detect
    always_comb begin
        map_addr = '0;
        if (DrawX < 10'd640 && DrawY < 10'd480)
            map_addr = {5'd0, DrawY[9:4]} * COLS + {5'd0, DrawX[9:4]};
        latch       = (DrawX == 10'd0) && (DrawY == 10'd480);
        frame_start = latch && Reset_n;
    end

    // Sprite hit test in 11 bits so a shadow near 1023 cannot wrap
    always_comb begin
        x_e     = {1'b0, x1_q};
        y_e     = {1'b0, y1_q};
        px_lo   = {1'b0, px_s_q};
        py_lo   = {1'b0, py_s_q};
        px_hi   = px_lo + SPAN;
        py_hi   = py_lo + SPAN;
        hit     = (x_e >= px_lo) && (x_e <= px_hi)
               && (y_e >= py_lo) && (y_e <= py_hi);
        on_edge = (x_e == px_lo) || (x_e == px_hi)
               || (y_e == py_lo) || (y_e == py_hi);
    end

    // Next-state: pipeline capture, colour select, shadow and palette
    always_comb begin
        x1_d   = DrawX;
        y1_d   = DrawY;
        b1_d   = blank_in;
        h1_d   = hs_in;
        v1_d   = vs_in;
        hs_d   = h1_q;
        vs_d   = v1_q;
        blank_d = b1_q;
        if (!b1_q)
            rgb_d = '0;
        else if (hit && on_edge)
            rgb_d = PLAYER_EDGE;
        else if (hit)
            rgb_d = PLAYER_FILL;
        else
            rgb_d = pal_q[map_data];
        px_s_d = px_s_q;
        py_s_d = py_s_q;
        if (latch) begin
            px_s_d = player_x;
            py_s_d = player_y;
        end
        pal_d = pal_q;
        if (pal_we)
            pal_d[pal_addr] = pal_data;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x1_q    <= '0;
            y1_q    <= '0;
            b1_q    <= 1'b0;
            h1_q    <= 1'b1;
            v1_q    <= 1'b1;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            px_s_q  <= 10'h3FF;
            py_s_q  <= 10'h3FF;
            for (int i = 0; i < 16; i++)
                pal_q[i] <= '0;
        end else begin
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            b1_q    <= b1_d;
            h1_q    <= h1_d;
            v1_q    <= v1_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            px_s_q  <= px_s_d;
            py_s_q  <= py_s_d;
            pal_q   <= pal_d;
        end
    end

    assign Red       = rgb_q[23:16];
    assign Green     = rgb_q[15:8];
    assign Blue      = rgb_q[7:0];
    assign hs_out    = hs_q;
    assign vs_out    = vs_q;
    assign blank_out = blank_q;
endmodule

// File: tb/tb_tile_sprite_renderer.sv
// tb_tile_sprite_renderer: directed plus randomized pixel stream
// checked against a pixel-level colour model.
module tb_tile_sprite_renderer;
    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank_in, hs_in, vs_in;
    logic [10:0] map_addr;
    logic [3:0]  map_data;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic [9:0]  player_x, player_y;
    logic [7:0]  Red, Green, Blue;
    logic        hs_out, vs_out, blank_out, frame_start;

    int checks   = 0;
    int failures = 0;

    logic [23:0] pal_m [16];
    int          pxs, pys;
    int          p1x, p1y;
    logic        p1b, p1h, p1v;
    logic [3:0]  mem [2048];

    tile_sprite_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .DrawX(DrawX), .DrawY(DrawY),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .map_addr(map_addr), .map_data(map_data),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .player_x(player_x), .player_y(player_y),
        .Red(Red), .Green(Green), .Blue(Blue),
        .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
        .frame_start(frame_start)
    );

    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    // External synchronous tile-map RAM
    always @(posedge Clk) map_data <= mem[map_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int x, input int y,
                                            input logic b);
        int tile;
        if (!b) return 24'h0;
        if (x >= pxs && x <= pxs + 11 && y >= pys && y <= pys + 11) begin
            if (x == pxs || x == pxs + 11 || y == pys || y == pys + 11)
                return 24'h000000;
            return 24'hFF0000;
        end
        if (x < 640 && y < 480) tile = ((x / 16) + (y / 16)) & 15;
        else tile = 0;
        return pal_m[tile];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) pal_m[i] = 24'h0;
        pxs = 1023;
        pys = 1023;
        p1x = 0;
        p1y = 0;
        p1b = 1'b0;
        p1h = 1'b1;
        p1v = 1'b1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rgb", 32'({Red, Green, Blue}), 32'h0);
        chk("rst_hs", 32'(hs_out), 32'h1);
        chk("rst_vs", 32'(vs_out), 32'h1);
        chk("rst_blank", 32'(blank_out), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
    endtask

    // One pixel clock: combinational checks, edge, registered checks
    task automatic tick();
        int dx, dy, ea;
        logic [23:0] e_rgb;
        logic e_h, e_v, e_b;
        #1;
        dx = int'(DrawX);
        dy = int'(DrawY);
        ea = (dx < 640 && dy < 480) ? (dy / 16) * 40 + dx / 16 : 0;
        chk("map_addr", map_addr, 32'(ea));
        chk("frame_start", 32'(frame_start), 32'(dx == 0 && dy == 480));
        @(posedge Clk);
        e_rgb = ref_rgb(p1x, p1y, p1b);
        e_h = p1h;
        e_v = p1v;
        e_b = p1b;
        if (pal_we) pal_m[pal_addr] = pal_data;
        if (dx == 0 && dy == 480) begin
            pxs = int'(player_x);
            pys = int'(player_y);
        end
        p1x = dx;
        p1y = dy;
        p1b = blank_in;
        p1h = hs_in;
        p1v = vs_in;
        #1;
        chk("rgb", 32'({Red, Green, Blue}), 32'(e_rgb));
        chk("hs_out", 32'(hs_out), 32'(e_h));
        chk("vs_out", 32'(vs_out), 32'(e_v));
        chk("blank_out", 32'(blank_out), 32'(e_b));
    endtask

    task automatic pix(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank_in = b;
        tick();
    endtask

    task automatic wr(input int a, input logic [23:0] d, input int x,
                      input int y);
        pal_we = 1'b1;
        pal_addr = 4'(a);
        pal_data = d;
        pix(x, y, 1'b1);
        pal_we = 1'b0;
    endtask

    initial begin
        int x, y;
        Reset_n = 1'b0;
        DrawX = '0;
        DrawY = '0;
        blank_in = 1'b1;
        hs_in = 1'b1;
        vs_in = 1'b1;
        pal_we = 1'b0;
        pal_addr = '0;
        pal_data = '0;
        player_x = '0;
        player_y = '0;
        for (int a = 0; a < 2048; a++)
            mem[a] = (a < 1200) ? 4'(((a % 40) + (a / 40)) & 15) : 4'h0;
        model_reset();

        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs();
        chk("rst_map_addr", map_addr, 32'h0);
        Reset_n = 1'b1;

        pix(37, 18, 1'b1);
        pix(37, 18, 1'b1);
        for (int i = 0; i < 16; i++)
            wr(i, {8'(i * 16), 16'h0}, 700, 10);
        pix(37, 18, 1'b1);
        pix(639, 479, 1'b1);
        pix(700, 100, 1'b1);
        pix(200, 200, 1'b0);
        pix(320, 240, 1'b1);
        pix(0, 0, 1'b1);

        player_x = 10'd100;
        player_y = 10'd50;
        pix(799, 479, 1'b0);
        pix(0, 480, 1'b0);
        pix(1, 480, 1'b0);
        pix(100, 50, 1'b1);
        pix(105, 55, 1'b1);
        pix(111, 61, 1'b1);
        pix(112, 55, 1'b1);
        pix(110, 61, 1'b1);
        pix(99, 55, 1'b1);

        pix(0, 200, 1'b1);
        player_x = 10'd300;
        pix(105, 210, 1'b1);
        pix(105, 55, 1'b1);
        pix(305, 55, 1'b1);
        pix(0, 480, 1'b0);
        pix(305, 55, 1'b1);
        pix(300, 50, 1'b1);
        pix(105, 55, 1'b1);

        player_x = 10'd1020;
        player_y = 10'd470;
        pix(0, 480, 1'b0);
        for (int yy = 468; yy < 480; yy++)
            for (int xx = 0; xx < 8; xx++)
                pix(xx, yy, 1'b1);
        pix(1021, 471, 1'b1);
        pix(1023, 475, 1'b1);
        pix(639, 475, 1'b1);

        pix(48, 0, 1'b1);
        wr(3, 24'h00FF00, 48, 0);
        pix(0, 0, 1'b1);
        pix(0, 0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                player_x = 10'($urandom_range(0, 650));
                player_y = 10'($urandom_range(0, 490));
            end
            if ($urandom_range(0, 2) == 0) begin
                x = pxs + int'($urandom_range(0, 13)) - 1;
                y = pys + int'($urandom_range(0, 13)) - 1;
            end else begin
                x = int'($urandom_range(0, 799));
                y = int'($urandom_range(0, 524));
            end
            if (x < 0) x = 0;
            if (y < 0) y = 0;
            if (x > 1023) x = 1023;
            if (y > 1023) y = 1023;
            if ($urandom_range(0, 19) == 0) begin
                x = 0;
                y = 480;
            end
            hs_in = 1'($urandom_range(0, 1));
            vs_in = 1'($urandom_range(0, 1));
            pal_we = ($urandom_range(0, 3) == 0);
            pal_addr = 4'($urandom_range(0, 15));
            pal_data = 24'($urandom);
            pix(x, y, ($urandom_range(0, 3) != 0));
        end
        pal_we = 1'b0;

        hs_in = 1'b0;
        vs_in = 1'b0;
        pix(50, 50, 1'b1);
        pix(51, 50, 1'b1);
        pix(52, 50, 1'b1);
        DrawX = 10'd53;
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hs_in = (i % 3) != 0;
            vs_in = (i % 2) != 0;
            pix(60 + i, 50, 1'b1);
        end
        hs_in = 1'b1;
        vs_in = 1'b1;
        player_x = 10'd100;
        player_y = 10'd50;
        wr(9, 24'h123456, 700, 0);
        wr(10, 24'h654321, 700, 0);
        pix(105, 55, 1'b1);
        pix(100, 50, 1'b1);
        pix(111, 61, 1'b1);
        pix(0, 0, 1'b1);
        pix(0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
